// File: rtl/exp7_sequenciador_leds.sv
// LED sequence playback controller: walks RAM addresses 0..limite, showing each value then a gap.
// Optional final all-on blink guarded by SEQ_PISCA_FINAL_EN.
module exp7_sequenciador_leds #(
    parameter int unsigned T_ON  = 50,
    parameter int unsigned T_OFF = 25
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       cancelar,
    input  logic [3:0] limite,
    input  logic [3:0] dado,
    output logic [3:0] endereco,
    output logic [3:0] leds,
    output logic       ocupado,
    output logic       fim,
    output logic [3:0] db_estado
);

    localparam int unsigned TMax = (T_ON > T_OFF) ? T_ON : T_OFF;
    localparam int unsigned TW   = $clog2(TMax + 1);
    localparam logic [TW-1:0] TOnLast  = TW'(T_ON - 1);
    localparam logic [TW-1:0] TOffLast = TW'(T_OFF - 1);

    typedef enum logic [3:0] {
        StOcioso  = 4'h0,
        StCarrega = 4'h1,
        StAcende  = 4'h2,
        StApaga   = 4'h3,
`ifdef SEQ_PISCA_FINAL_EN
        StPisca   = 4'h4,
`endif
        StFim     = 4'hF
    } estado_t;

    estado_t         estado;
    logic [3:0]      indice;
    logic [3:0]      lim_r;
    logic [TW-1:0]   timer;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= StOcioso;
            indice <= '0;
            lim_r  <= '0;
            timer  <= '0;
        end else if (cancelar && estado != StOcioso) begin
            estado <= StOcioso;
            timer  <= '0;
        end else begin
            case (estado)
                StOcioso: begin
                    if (iniciar) begin
                        lim_r  <= limite;
                        indice <= '0;
                        estado <= StCarrega;
                    end
                end
                StCarrega: begin
                    timer  <= '0;
                    estado <= StAcende;
                end
                StAcende: begin
                    if (timer == TOnLast) begin
                        timer  <= '0;
                        estado <= StApaga;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                StApaga: begin
                    if (timer == TOffLast) begin
                        timer <= '0;
                        // index stops at lim_r, so it never wraps even with lim_r = 15
                        if (indice == lim_r) begin
`ifdef SEQ_PISCA_FINAL_EN
                            estado <= StPisca;
`else
                            estado <= StFim;
`endif
                        end else begin
                            indice <= indice + 1'b1;
                            estado <= StCarrega;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
`ifdef SEQ_PISCA_FINAL_EN
                StPisca: begin
                    if (timer == TOnLast) begin
                        timer  <= '0;
                        estado <= StFim;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
`endif
                StFim: estado <= StOcioso;
                default: begin
                    estado <= StOcioso;
                    timer  <= '0;
                end
            endcase
        end
    end

    always_comb begin
        endereco  = 4'h0;
        leds      = 4'h0;
        ocupado   = 1'b0;
        fim       = 1'b0;
        db_estado = estado;
        case (estado)
            StCarrega: begin
                endereco = indice;
                ocupado  = 1'b1;
            end
            StAcende: begin
                endereco = indice;
                leds     = dado;
                ocupado  = 1'b1;
            end
            StApaga: begin
                endereco = indice;
                ocupado  = 1'b1;
            end
`ifdef SEQ_PISCA_FINAL_EN
            StPisca: begin
                endereco = indice;
                leds     = 4'hF;
                ocupado  = 1'b1;
            end
`endif
            StFim: fim = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_exp7_sequenciador_leds.sv
// Self-checking bench: per-cycle comparison of all outputs against a timeline model
// computed from item index / phase arithmetic.
module tb_exp7_sequenciador_leds;

    localparam int T_ON  = 3;
    localparam int T_OFF = 2;
    localparam int P     = 1 + T_ON + T_OFF;

    logic       clock, reset, iniciar, cancelar;
    logic [3:0] limite, dado, endereco, leds, db_estado;
    logic       ocupado, fim;
    logic [3:0] ram [16];

    int n_asrt = 0;
    int n_fail = 0;

    exp7_sequenciador_leds #(.T_ON(T_ON), .T_OFF(T_OFF)) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .cancelar  (cancelar),
        .limite    (limite),
        .dado      (dado),
        .endereco  (endereco),
        .leds      (leds),
        .ocupado   (ocupado),
        .fim       (fim),
        .db_estado (db_estado)
    );

    assign dado = ram[endereco];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_asrt++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, ".estado"}, db_estado, 4'h0);
        chk({tag, ".leds"}, leds, 4'h0);
        chk({tag, ".endereco"}, endereco, 4'h0);
        chk({tag, ".ocupado"}, {3'b0, ocupado}, 4'h0);
        chk({tag, ".fim"}, {3'b0, fim}, 4'h0);
    endtask

    function automatic int last_cycle(input int n);
`ifdef SEQ_PISCA_FINAL_EN
        return 1 + n * P + T_ON;
`else
        return 1 + n * P;
`endif
    endfunction

    // Expected outputs t cycles after the start edge for n items.
    task automatic check_play(input string tag, input int t, input int n);
        int item, ph;
        logic [3:0] e_st, e_leds, e_addr;
        logic e_ocup, e_fim;
        e_fim = 1'b0;
        e_ocup = 1'b1;
        e_leds = 4'h0;
        if (t == last_cycle(n)) begin
            e_st = 4'hF;
            e_addr = 4'h0;
            e_ocup = 1'b0;
            e_fim = 1'b1;
        end else if (t > n * P) begin
            e_st = 4'h4;
            e_leds = 4'hF;
            e_addr = 4'(n - 1);
        end else begin
            item = (t - 1) / P;
            ph = (t - 1) % P;
            e_addr = 4'(item);
            if (ph == 0) e_st = 4'h1;
            else if (ph <= T_ON) begin
                e_st = 4'h2;
                e_leds = ram[item];
            end else e_st = 4'h3;
        end
        chk($sformatf("%s.t%0d.estado", tag, t), db_estado, e_st);
        chk($sformatf("%s.t%0d.leds", tag, t), leds, e_leds);
        chk($sformatf("%s.t%0d.endereco", tag, t), endereco, e_addr);
        chk($sformatf("%s.t%0d.ocupado", tag, t), {3'b0, ocupado}, {3'b0, e_ocup});
        chk($sformatf("%s.t%0d.fim", tag, t), {3'b0, fim}, {3'b0, e_fim});
    endtask

    // Start a playback and check every cycle; optional cancel during cycle cancel_at.
    task automatic play(input string tag, input int lim, input int cancel_at,
                        input bit hold, input bit noisy);
        int n, last;
        n = lim + 1;
        last = last_cycle(n);
        limite = 4'(lim);
        iniciar = 1'b1;
        step();
        for (int t = 1; t <= last; t++) begin
            iniciar = hold ? 1'b1 : (noisy ? 1'($urandom) : 1'b0);
            if (noisy) limite = 4'($urandom);
            check_play(tag, t, n);
            if (t == last) iniciar = 1'b0;
            if (t == cancel_at) begin
                iniciar = 1'b0;
                cancelar = 1'b1;
                step();
                cancelar = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    check_idle({tag, ".cancel"});
                    step();
                end
                return;
            end
            step();
        end
        check_idle({tag, ".after"});
    endtask

    initial begin
        reset = 1'b0;
        iniciar = 1'b0;
        cancelar = 1'b0;
        limite = 4'h0;
        for (int i = 0; i < 16; i++) ram[i] = 4'($urandom);
        #12;
        check_idle("reset");
        reset = 1'b1;
        step();
        check_idle("idle");

        ram[0] = 4'h1; ram[1] = 4'h2; ram[2] = 4'h4; ram[3] = 4'h8;
        play("seq4", 3, 0, 1'b0, 1'b0);

        ram[0] = 4'hA;
        play("single_hold", 0, 0, 1'b1, 1'b0);

        for (int i = 0; i < 16; i++) ram[i] = 4'($urandom_range(1, 15));
        play("cancel", 3, 1 + P + 2, 1'b0, 1'b0);

        // async reset between edges in the first gap
        limite = 4'h2;
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        for (int t = 1; t <= 5; t++) begin
            check_play("rst", t, 3);
            if (t < 5) step();
        end
        #2 reset = 1'b0;
        #1 check_idle("rst_async");
        #2 reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check_idle("rst_release");
        end

        for (int i = 0; i < 16; i++) ram[i] = 4'($urandom_range(1, 15));
        play("full16", 15, 0, 1'b0, 1'b1);

        for (int r = 0; r < 8; r++) begin
            int lim, cut;
            for (int i = 0; i < 16; i++) ram[i] = 4'($urandom);
            lim = int'($urandom_range(0, 15));
            cut = ($urandom % 2 == 0) ? int'($urandom_range(1, last_cycle(lim + 1) - 1)) : 0;
            play($sformatf("rand%0d", r), lim, cut, 1'b0, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
